fpu_wb_ctrl: RTL and testbench

- Writeback/retire controller on the consuming side of the FPU execution unit.
- Accepts one FPU issue at a time, records its destination register and class (FPR or GPR), and waits for the unit's completion.
- Drives the FP or integer register-file write port.
- Accrues the unit's registered exception flags into a sticky fflags register that the CSR file can read and overwrite.

---
 rtl/fpu_wb_ctrl.sv | 141 ++++++++++++++
 tb/tb_fpu_wb_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_wb_ctrl.sv
// Writeback/retire controller for the FPU execution unit: tracks one in-flight
// op, drives the FPR or GPR write port, and accrues sticky fflags.
module fpu_wb_ctrl #(
   parameter int FPLEN   = 32,
   parameter int TMO_CYC = 64
) (
   input  logic             clk,
   input  logic             rst_l,
   input  logic             issue_valid,
   output logic             issue_ready,
   input  logic [4:0]       issue_rd,
   input  logic             issue_to_gpr,
   input  logic             issue_flush,
   input  logic             fpu_complete,
   input  logic             fpu_complete_rd,
   input  logic [FPLEN-1:0] fpu_result_1,
   input  logic [31:0]      fpu_result_rd,
   input  logic [4:0]       sflags,
   output logic             fpr_we,
   output logic [4:0]       fpr_waddr,
   output logic [FPLEN-1:0] fpr_wdata,
   output logic             gpr_we,
   output logic [4:0]       gpr_waddr,
   output logic [31:0]      gpr_wdata,
   input  logic             fflags_wr_en,
   input  logic [4:0]       fflags_wr_data,
   output logic [4:0]       fflags,
   output logic             fpu_busy,
   output logic             fpu_stall,
   output logic             proto_err,
   output logic             timeout_err,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      WB    = 2'd2,
      DRAIN = 2'd3
   } state_t;

   localparam int TW = $clog2(TMO_CYC + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

   state_t        state;
   logic [4:0]    rd_q;
   logic          gpr_q;
   logic [TW-1:0] timer;

   // Issue handshake: an op transfers on a cycle where issue_valid && issue_ready;
   // issue_valid while issue_ready is low is dropped, not held, and flagged by fpu_stall.
   assign issue_ready = (state == IDLE);
   assign fpu_busy    = (state != IDLE);
   assign fpu_stall   = issue_valid & ~issue_ready;
   assign dbg_state   = state;

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state       <= IDLE;
         rd_q        <= '0;
         gpr_q       <= 1'b0;
         timer       <= '0;
         fpr_we      <= 1'b0;
         fpr_waddr   <= '0;
         fpr_wdata   <= '0;
         gpr_we      <= 1'b0;
         gpr_waddr   <= '0;
         gpr_wdata   <= '0;
         fflags      <= '0;
         proto_err   <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         fpr_we      <= 1'b0;
         fpr_waddr   <= '0;
         fpr_wdata   <= '0;
         gpr_we      <= 1'b0;
         gpr_waddr   <= '0;
         gpr_wdata   <= '0;
         proto_err   <= 1'b0;
         timeout_err <= 1'b0;

         case (state)
            IDLE: begin
               if (fpu_complete) proto_err <= 1'b1;
               if (issue_valid) begin
                  rd_q  <= issue_rd;
                  gpr_q <= issue_to_gpr;
                  timer <= '0;
                  state <= BUSY;
               end
            end
            BUSY: begin
               timer <= timer + TW'(1);
               if (issue_flush && fpu_complete) begin
                  state <= IDLE;
               end else if (issue_flush) begin
                  state <= DRAIN;
               end else if (fpu_complete && (fpu_complete_rd == gpr_q)) begin
                  // Write strobes are registered here so they are high during WB.
                  state <= WB;
                  if (gpr_q) begin
                     if (rd_q != 5'd0) begin
                        gpr_we    <= 1'b1;
                        gpr_waddr <= rd_q;
                        gpr_wdata <= fpu_result_rd;
                     end
                  end else begin
                     fpr_we    <= 1'b1;
                     fpr_waddr <= rd_q;
                     fpr_wdata <= fpu_result_1;
                  end
               end else if (fpu_complete) begin
                  proto_err <= 1'b1;
                  state     <= IDLE;
               end else if (timer >= TMO_LAST) begin
                  timeout_err <= 1'b1;
                  state       <= IDLE;
               end
            end
            WB: begin
               state <= IDLE;
            end
            DRAIN: begin
               timer <= timer + TW'(1);
               if (fpu_complete) begin
                  state <= IDLE;
               end else if (timer >= TMO_LAST) begin
                  timeout_err <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         // sflags belong to the op retiring in WB; a CSR write in that cycle overrides them.
         if (fflags_wr_en)     fflags <= fflags_wr_data;
         else if (state == WB) fflags <= fflags | sflags;
      end
   end

endmodule

// File: tb/tb_fpu_wb_ctrl.sv
// Directed bench for fpu_wb_ctrl: hand-computed vectors, write-port scoreboard,
// and a single summary line.
module tb_fpu_wb_ctrl;

   localparam int FPLEN   = 32;
   localparam int TMO_CYC = 8;

   logic             clk;
   logic             rst_l;
   logic             issue_valid;
   logic             issue_ready;
   logic [4:0]       issue_rd;
   logic             issue_to_gpr;
   logic             issue_flush;
   logic             fpu_complete;
   logic             fpu_complete_rd;
   logic [FPLEN-1:0] fpu_result_1;
   logic [31:0]      fpu_result_rd;
   logic [4:0]       sflags;
   logic             fpr_we;
   logic [4:0]       fpr_waddr;
   logic [FPLEN-1:0] fpr_wdata;
   logic             gpr_we;
   logic [4:0]       gpr_waddr;
   logic [31:0]      gpr_wdata;
   logic             fflags_wr_en;
   logic [4:0]       fflags_wr_data;
   logic [4:0]       fflags;
   logic             fpu_busy;
   logic             fpu_stall;
   logic             proto_err;
   logic             timeout_err;
   logic [1:0]       dbg_state;

   int n_vec;
   int n_err;

   // {is_gpr, waddr, wdata}
   logic [37:0] exp_q[$];

   fpu_wb_ctrl #(.FPLEN(FPLEN), .TMO_CYC(TMO_CYC)) dut (
      .clk            (clk),
      .rst_l          (rst_l),
      .issue_valid    (issue_valid),
      .issue_ready    (issue_ready),
      .issue_rd       (issue_rd),
      .issue_to_gpr   (issue_to_gpr),
      .issue_flush    (issue_flush),
      .fpu_complete   (fpu_complete),
      .fpu_complete_rd(fpu_complete_rd),
      .fpu_result_1   (fpu_result_1),
      .fpu_result_rd  (fpu_result_rd),
      .sflags         (sflags),
      .fpr_we         (fpr_we),
      .fpr_waddr      (fpr_waddr),
      .fpr_wdata      (fpr_wdata),
      .gpr_we         (gpr_we),
      .gpr_waddr      (gpr_waddr),
      .gpr_wdata      (gpr_wdata),
      .fflags_wr_en   (fflags_wr_en),
      .fflags_wr_data (fflags_wr_data),
      .fflags         (fflags),
      .fpu_busy       (fpu_busy),
      .fpu_stall      (fpu_stall),
      .proto_err      (proto_err),
      .timeout_err    (timeout_err),
      .dbg_state      (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      issue_valid     = 1'b0;
      issue_rd        = 5'd0;
      issue_to_gpr    = 1'b0;
      issue_flush     = 1'b0;
      fpu_complete    = 1'b0;
      fpu_complete_rd = 1'b0;
      fpu_result_1    = '0;
      fpu_result_rd   = '0;
      sflags          = 5'd0;
      fflags_wr_en    = 1'b0;
      fflags_wr_data  = 5'd0;
   endtask

   task automatic push_wr(input logic g, input logic [4:0] a, input logic [31:0] d);
      exp_q.push_back({g, a, d});
   endtask

   // Issues one op in the current cycle and advances into BUSY.
   task automatic do_issue(input logic [4:0] rd, input logic to_gpr);
      issue_valid  = 1'b1;
      issue_rd     = rd;
      issue_to_gpr = to_gpr;
      tick();
      issue_valid  = 1'b0;
   endtask

   task automatic csr_write(input logic [4:0] v);
      fflags_wr_en   = 1'b1;
      fflags_wr_data = v;
      tick();
      fflags_wr_en   = 1'b0;
      chk("csr_wr", 32'(fflags), 32'(v));
   endtask

   // scoreboard: every observed write must match the oldest expected write
   always @(negedge clk) begin
      if (rst_l && (fpr_we || gpr_we)) begin
         logic [37:0] e;
         chk("wr_both", 32'(fpr_we & gpr_we), 32'd0);
         if (exp_q.size() == 0) begin
            chk("unexp_wr", 32'({fpr_we, gpr_we}), 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("wr_is_gpr", 32'(gpr_we), 32'(e[37]));
            chk("wr_addr", 32'(gpr_we ? gpr_waddr : fpr_waddr), 32'(e[36:32]));
            chk("wr_data", gpr_we ? gpr_wdata : fpr_wdata, e[31:0]);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      n_vec = 0;
      n_err = 0;
      clear_inputs();
      rst_l = 1'b0;
      #3;
      chk("rst_fpr_we", 32'(fpr_we), 32'd0);
      chk("rst_gpr_we", 32'(gpr_we), 32'd0);
      chk("rst_fflags", 32'(fflags), 32'd0);
      chk("rst_proto", 32'(proto_err), 32'd0);
      chk("rst_tmo", 32'(timeout_err), 32'd0);
      chk("rst_busy", 32'(fpu_busy), 32'd0);
      chk("rst_ready", 32'(issue_ready), 32'd1);
      chk("rst_state", 32'(dbg_state), 32'd0);
      #10 rst_l = 1'b1;
      tick();

      // FPR op, complete 3 cycles after issue
      do_issue(5'd5, 1'b0);
      chk("fpr_busy", 32'(fpu_busy), 32'd1);
      chk("fpr_ready0", 32'(issue_ready), 32'd0);
      tick();
      tick();
      fpu_complete = 1'b1;
      fpu_result_1 = 32'h3FC0_0000;
      push_wr(1'b0, 5'd5, 32'h3FC0_0000);
      tick();
      fpu_complete = 1'b0;
      sflags       = 5'b00001;
      chk("fpr_we", 32'(fpr_we), 32'd1);
      chk("fpr_waddr", 32'(fpr_waddr), 32'd5);
      chk("fpr_wdata", fpr_wdata, 32'h3FC0_0000);
      chk("fpr_ff_early", 32'(fflags), 32'd0);
      tick();
      sflags = 5'd0;
      chk("fpr_ff", 32'(fflags), 32'h01);
      chk("fpr_ready", 32'(issue_ready), 32'd1);
      chk("fpr_we_off", 32'(fpr_we), 32'd0);

      // GPR op rd=10
      do_issue(5'd10, 1'b1);
      fpu_complete    = 1'b1;
      fpu_complete_rd = 1'b1;
      fpu_result_rd   = 32'd1;
      push_wr(1'b1, 5'd10, 32'd1);
      tick();
      fpu_complete = 1'b0;
      sflags       = 5'b00100;
      chk("gpr_we", 32'(gpr_we), 32'd1);
      chk("gpr_waddr", 32'(gpr_waddr), 32'd10);
      chk("gpr_wdata", gpr_wdata, 32'd1);
      tick();
      sflags = 5'd0;
      chk("gpr_ff", 32'(fflags), 32'h05);

      // GPR op rd=0: no write, flags still accrue
      do_issue(5'd0, 1'b1);
      fpu_complete    = 1'b1;
      fpu_complete_rd = 1'b1;
      fpu_result_rd   = 32'h0000_DEAD;
      tick();
      fpu_complete = 1'b0;
      sflags       = 5'b01000;
      chk("x0_we", 32'(gpr_we), 32'd0);
      chk("x0_waddr", 32'(gpr_waddr), 32'd0);
      chk("x0_wdata", gpr_wdata, 32'd0);
      chk("x0_state_wb", 32'(dbg_state), 32'd2);
      tick();
      sflags = 5'd0;
      chk("x0_ff", 32'(fflags), 32'h0D);
      fpu_complete_rd = 1'b0;
      csr_write(5'd0);

      // flush in BUSY, later complete is drained
      do_issue(5'd3, 1'b0);
      issue_flush = 1'b1;
      tick();
      issue_flush = 1'b0;
      chk("drain_busy", 32'(fpu_busy), 32'd1);
      chk("drain_state", 32'(dbg_state), 32'd3);
      tick();
      fpu_complete = 1'b1;
      fpu_result_1 = 32'h4000_0000;
      tick();
      fpu_complete = 1'b0;
      sflags       = 5'h10;
      chk("drain_ready", 32'(issue_ready), 32'd1);
      chk("drain_we", 32'(fpr_we), 32'd0);
      tick();
      sflags = 5'd0;
      chk("drain_ff", 32'(fflags), 32'd0);

      // flush coincident with complete
      do_issue(5'd4, 1'b0);
      issue_flush  = 1'b1;
      fpu_complete = 1'b1;
      tick();
      issue_flush  = 1'b0;
      fpu_complete = 1'b0;
      sflags       = 5'h10;
      chk("fc_ready", 32'(issue_ready), 32'd1);
      chk("fc_we", 32'(fpr_we), 32'd0);
      tick();
      sflags = 5'd0;
      chk("fc_ff", 32'(fflags), 32'd0);

      // class mismatch on completion
      do_issue(5'd6, 1'b0);
      fpu_complete    = 1'b1;
      fpu_complete_rd = 1'b1;
      tick();
      fpu_complete    = 1'b0;
      fpu_complete_rd = 1'b0;
      chk("pe_pulse", 32'(proto_err), 32'd1);
      chk("pe_ready", 32'(issue_ready), 32'd1);
      chk("pe_we", 32'({fpr_we, gpr_we}), 32'd0);
      tick();
      chk("pe_clear", 32'(proto_err), 32'd0);

      // completion in IDLE
      fpu_complete = 1'b1;
      tick();
      fpu_complete = 1'b0;
      chk("idle_pe", 32'(proto_err), 32'd1);
      chk("idle_pe_busy", 32'(fpu_busy), 32'd0);
      tick();
      chk("idle_pe_clr", 32'(proto_err), 32'd0);

      // watchdog, with a stalled second issue
      do_issue(5'd7, 1'b0);
      issue_valid = 1'b1;
      issue_rd    = 5'd8;
      #1;
      chk("stall", 32'(fpu_stall), 32'd1);
      for (int i = 1; i <= TMO_CYC - 1; i++) begin
         tick();
         issue_valid = 1'b0;
         chk("tmo_early", 32'(timeout_err), 32'd0);
      end
      chk("tmo_busy", 32'(fpu_busy), 32'd1);
      tick();
      chk("tmo_pulse", 32'(timeout_err), 32'd1);
      chk("tmo_ready", 32'(issue_ready), 32'd1);
      tick();
      chk("tmo_clear", 32'(timeout_err), 32'd0);
      chk("tmo_stall0", 32'(fpu_stall), 32'd0);

      // CSR write collides with accrual in WB
      csr_write(5'h01);
      do_issue(5'd1, 1'b0);
      fpu_complete = 1'b1;
      fpu_result_1 = 32'h4049_0FDB;
      push_wr(1'b0, 5'd1, 32'h4049_0FDB);
      tick();
      fpu_complete   = 1'b0;
      sflags         = 5'h02;
      fflags_wr_en   = 1'b1;
      fflags_wr_data = 5'h04;
      chk("col_we", 32'(fpr_we), 32'd1);
      tick();
      sflags       = 5'd0;
      fflags_wr_en = 1'b0;
      chk("col_ff", 32'(fflags), 32'h04);

      // asynchronous reset in WB; the lost op completes afterwards in IDLE
      do_issue(5'd9, 1'b1);
      fpu_complete    = 1'b1;
      fpu_complete_rd = 1'b1;
      fpu_result_rd   = 32'h55;
      tick();
      fpu_complete    = 1'b0;
      fpu_complete_rd = 1'b0;
      chk("rwb_we_pre", 32'(gpr_we), 32'd1);
      #1 rst_l = 1'b0;
      #1;
      chk("rwb_we", 32'(gpr_we), 32'd0);
      chk("rwb_waddr", 32'(gpr_waddr), 32'd0);
      chk("rwb_wdata", gpr_wdata, 32'd0);
      chk("rwb_ff", 32'(fflags), 32'd0);
      chk("rwb_busy", 32'(fpu_busy), 32'd0);
      chk("rwb_ready", 32'(issue_ready), 32'd1);
      #1 rst_l = 1'b1;
      fpu_complete    = 1'b1;
      fpu_complete_rd = 1'b1;
      tick();
      clear_inputs();
      chk("lost_pe", 32'(proto_err), 32'd1);
      tick();

      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
